fb_reader: RTL and testbench
============================

# fb_reader

Framebuffer pixel fetcher, directly upstream of the `vga` timing generator. It reads a linear 24-bit RGB framebuffer from memory over a single-outstanding req/ack bus master and buffers pixels in a FIFO. It delivers one pixel per `pix_rd` pulse issued by the display stage during the active region. A `frame_start` pulse, derived from VS, restarts the fetch at the first pixel.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `FIFO_DEPTH`, 256, pixel FIFO entries; power of two, ≥2
- `BASE_ADDR`, 32'h0000_0000, byte address of pixel (0,0); 4-byte aligned
- `pixel_clk`  in  1  sole clock; all logic on posedge
- `pixel_rst`  in  1  reset; asynchronous, active-high
- `frame_start`  in  1  one-cycle pulse; flush and restart at pixel 0
- `pix_rd`  in  1  consumer takes one pixel this cycle
- `rgb`  out  24  registered pixel {R,G,B}
- `mem_req`  out  1  bus request
- `mem_addr`  out  32  byte address; steps by 4
- `mem_ack`  in  1  request accepted; `mem_rdata` valid this cycle
- `mem_rdata`  in  32  {8'h00, R, G, B}; bits [31:24] ignored
- `underflow`  out  1  sticky; set on `pix_rd` with FIFO empty
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Total pixels per frame: TOTAL = HDISP*VDISP. Pixel counter width: $clog2(TOTAL+1).
- The fetch FSM has five states: IDLE, REQ, WAIT, DRAIN, DONE. It enters IDLE on reset.
- IDLE:
  - `frame_start` → REQ, with addr = BASE_ADDR and count = 0.
- REQ:
  - `mem_req` = 1. `mem_req` and `mem_addr` stay stable until `mem_ack`.
  - On `mem_ack`, push `mem_rdata[23:0]`, then addr += 4 and count += 1.
  - After that push: if count == TOTAL → DONE; else if the FIFO becomes full → WAIT; else stay in REQ with the new address.
- WAIT:
  - `mem_req` = 0.
  - Return to REQ as soon as `fifo_level` < FIFO_DEPTH.
- DONE:
  - `mem_req` = 0. Stay here until `frame_start`.
- `frame_start` handling:
  - From IDLE, WAIT or DONE: flush the FIFO, reload addr/count, go to REQ.
  - From REQ with no ack that cycle: flush, go to DRAIN. The bus request is never abandoned.
  - From REQ with ack that cycle: discard the acked word, flush, go to REQ at BASE_ADDR.
- DRAIN:
  - Hold `mem_req` and `mem_addr` until `mem_ack`, and discard the returned data.
  - On ack → REQ at BASE_ADDR with count = 0. A further `frame_start` while in DRAIN changes nothing.
- Consumer side:
  - `pix_rd` with FIFO not empty: pop, and `rgb` ← head on the next edge.
  - `pix_rd` with FIFO empty: no pop, `underflow` ← 1, `rgb` ← underflow colour (see Configuration).
  - `pix_rd` = 0: `rgb` holds its value.
- Push and pop in the same cycle leave `fifo_level` unchanged. The FSM never pushes when the FIFO is full, because a request is raised only when space exists.
- `frame_start` together with `pix_rd`: the flush wins, the pop is ignored, `rgb` ← 24'h000000, and `underflow` clears.
- Address wrap past 32'hFFFF_FFFC is modulo 2^32. This is a legal configuration and needs no special handling.

## Timing
- Reset values: `rgb` = 0, `mem_req` = 0, `mem_addr` = BASE_ADDR, `underflow` = 0, `fifo_level` = 0, FSM = IDLE.
- `frame_start` at cycle N → `mem_req` = 1 with `mem_addr` = BASE_ADDR at N+1.
- `mem_ack` is legal in the first cycle of `mem_req`. Peak throughput is 1 pixel per cycle.
- Ack at cycle M → `fifo_level` increments at M+1. The next address is presented at M+1.
- Fetch-to-display latency: `pix_rd` at M+1 → the pixel appears on `rgb` at M+2.
- `pix_rd` → `rgb` latency is 1 cycle.
- `underflow` rises one cycle after the offending `pix_rd`.

## Configuration
- `FB_UNDERFLOW_MAGENTA_EN` defined: on an underflow read, `rgb` ← 24'hFF00FF, a debug-visible colour.
- `FB_UNDERFLOW_MAGENTA_EN` undefined: on an underflow read, `rgb` ← 24'h000000.
- `underflow` flag behaviour is identical in both builds.

## Structure
- Package `fb_reader_pkg` contains:
  - `PIX_W` = 24
  - FSM `typedef enum` {IDLE, REQ, WAIT, DRAIN, DONE}
  - `UNDERFLOW_RGB` constant
  - `pixel_t` typedef
- Sub-module `sync_fifo`: single-clock, parameterised width/depth, synchronous flush input, `level` output, registered read data.
- `fb_reader` contains the FSM, the address and pixel counters, and the consumer-side output register.

## Test plan
Bench parameters: HDISP=4, VDISP=2, FIFO_DEPTH=4, BASE_ADDR=32'h100; memory word at addr = {8'h00, addr[23:0]}.
- Reset mid-frame: assert `pixel_rst` while in REQ → all outputs at reset values immediately; after release, FSM stays IDLE with `mem_req` = 0 until `frame_start`.
- Full frame with zero-wait ack and `pix_rd` idle → 4 acks at 0x100, 0x104, 0x108, 0x10C; `fifo_level` reaches 4; FSM in WAIT; `mem_req` = 0.
- Drain at steady state: continuous `pix_rd` → `rgb` sequence 0x000100, 0x000104, … 0x00011C, exactly 8 fetches, then DONE.
- Underflow: `pix_rd` with FIFO empty → `underflow` = 1 next cycle; `rgb` = 0xFF00FF with the macro, 0x000000 without; `frame_start` clears `underflow`.
- `frame_start` while `mem_req` is waiting with 3 cycles of ack delay → `mem_req` held at the old address until ack; data discarded; next request at 0x100; `fifo_level` = 0.
- `frame_start` coincident with `mem_ack` and `pix_rd` → no push, no pop; `rgb` = 0; next `mem_addr` = 0x100.

Source files
------------

// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the framebuffer pixel fetcher.
// FB_UNDERFLOW_MAGENTA_EN selects a magenta underflow colour instead of black.
package fb_reader_pkg;

    localparam int PIX_W = 24;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        DONE
    } fetch_state_t;

    // Which source currently drives the rgb output.
    typedef enum logic [1:0] {
        RGB_FIFO,
        RGB_UNDERFLOW,
        RGB_BLACK
    } rgb_src_t;

`ifdef FB_UNDERFLOW_MAGENTA_EN
    localparam pixel_t UNDERFLOW_RGB = 24'hFF00FF;
`else
    localparam pixel_t UNDERFLOW_RGB = 24'h000000;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush, occupancy output and registered read data.
// rdata updates only on an accepted pop; flush resets pointers but leaves rdata alone.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fb_reader.sv
// Framebuffer pixel fetcher: single-outstanding bus master filling a pixel FIFO.
// FB_UNDERFLOW_MAGENTA_EN selects the colour shown on an underflow read.
module fb_reader
    import fb_reader_pkg::*;
#(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    localparam int TOTAL = HDISP * VDISP,
    localparam int CNT_W = $clog2(TOTAL + 1),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic             frame_start,
    input  logic             pix_rd,
    output pixel_t           rgb,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             underflow,
    output logic [LVL_W-1:0] fifo_level,
    output fetch_state_t     fsm_state
);

    // Handshake: a request is raised with a stable address and held until
    // mem_ack; the ack cycle carries mem_rdata and retires the request.

    fetch_state_t     state;
    logic [CNT_W-1:0] count;
    rgb_src_t         rgb_src;
    pixel_t           fifo_rdata;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [LVL_W-1:0] level_after_push;
    logic             full_after_push;
    logic             last_pix;
    logic             unused_rdata_hi;

    assign unused_rdata_hi = &{1'b0, mem_rdata[31:PIX_W]};

    // A frame_start flush overrides both the bus push and the consumer pop.
    assign push = (state == REQ) & mem_ack & ~frame_start;
    assign pop  = pix_rd & ~fifo_empty & ~frame_start;

    assign level_after_push = fifo_level + LVL_W'(1) - LVL_W'(pop);
    assign full_after_push  = (level_after_push == LVL_W'(FIFO_DEPTH));
    assign last_pix         = (count == CNT_W'(TOTAL - 1));
    assign fsm_state        = state;

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pixel_clk),
        .rst   (pixel_rst),
        .flush (frame_start),
        .push  (push),
        .wdata (mem_rdata[PIX_W-1:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .empty (fifo_empty)
    );

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= BASE_ADDR;
            count    <= '0;
        end else begin
            case (state)
                IDLE, WAIT, DONE: begin
                    if (frame_start) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                    end else if (state == WAIT && fifo_level < LVL_W'(FIFO_DEPTH)) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (frame_start) begin
                        // An acked word is simply dropped; otherwise the
                        // outstanding request must be retired in DRAIN.
                        if (mem_ack) begin
                            mem_addr <= BASE_ADDR;
                            count    <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        mem_addr <= mem_addr + 32'd4;
                        count    <= count + CNT_W'(1);
                        if (last_pix) begin
                            state   <= DONE;
                            mem_req <= 1'b0;
                        end else if (full_after_push) begin
                            state   <= WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state    <= REQ;
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            underflow <= 1'b0;
            rgb_src   <= RGB_BLACK;
        end else if (frame_start) begin
            underflow <= 1'b0;
            if (pix_rd) begin
                rgb_src <= RGB_BLACK;
            end
        end else if (pix_rd) begin
            if (fifo_empty) begin
                underflow <= 1'b1;
                rgb_src   <= RGB_UNDERFLOW;
            end else begin
                rgb_src <= RGB_FIFO;
            end
        end
    end

    // Every rgb source is a flop, so the output is glitch-free after the edge.
    always_comb begin
        rgb = '0;
        case (rgb_src)
            RGB_FIFO:      rgb = fifo_rdata;
            RGB_UNDERFLOW: rgb = UNDERFLOW_RGB;
            default:       rgb = '0;
        endcase
    end

endmodule

// File: tb/tb_fb_reader.sv
// Directed scoreboard bench for fb_reader: 4x2 frame, 4-entry FIFO, base 0x100.
module tb_fb_reader;
    import fb_reader_pkg::*;

`ifdef FB_UNDERFLOW_MAGENTA_EN
    localparam logic [23:0] UF_RGB = 24'hFF00FF;
`else
    localparam logic [23:0] UF_RGB = 24'h000000;
`endif

    logic         pixel_clk = 1'b0;
    logic         pixel_rst;
    logic         frame_start;
    logic         pix_rd;
    logic [23:0]  rgb;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [31:0]  mem_rdata = 32'h0;
    logic         underflow;
    logic [2:0]   fifo_level;
    fetch_state_t fsm_state;

    logic [23:0] exp_q[$];
    logic [31:0] addr_q[$];
    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic ack_en = 1'b1;

    fb_reader #(
        .HDISP      (4),
        .VDISP      (2),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (32'h100)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .rgb         (rgb),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .underflow   (underflow),
        .fifo_level  (fifo_level),
        .fsm_state   (fsm_state)
    );

    // Clock / watchdog
    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge pixel_clk);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req && n < 10) begin
            step();
            n++;
        end
        check(name, {31'b0, mem_req}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, {8'h0, rgb}, 32'h0);
        check({tag, "_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'h100);
        check({tag, "_uf"}, {31'b0, underflow}, 32'd0);
        check({tag, "_level"}, {29'b0, fifo_level}, 32'd0);
        check({tag, "_state"}, {29'b0, fsm_state}, {29'b0, IDLE});
    endtask

    // Bus responder: acks after ack_delay idle request cycles, checks each acked address.
    initial begin
        forever begin
            @(negedge pixel_clk);
            #1;
            mem_ack = 1'b0;
            if (!ack_en || !mem_req || pixel_rst) begin
                wait_cnt = 0;
            end else if (wait_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = {8'h00, mem_addr[23:0]};
                wait_cnt  = 0;
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ack_addr: got %h required no request", mem_addr);
                end else begin
                    check("ack_addr", mem_addr, addr_q.pop_front());
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    // rgb monitor: one cycle after each sampled pix_rd, compare against the scoreboard.
    initial begin
        logic taken;
        forever begin
            @(posedge pixel_clk);
            taken = pix_rd;
            #2;
            if (taken) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rgb: got %h required no pixel", rgb);
                end else begin
                    check("rgb", {8'h0, rgb}, {8'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int n;
        pixel_rst   = 1'b1;
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        pixel_rst = 1'b0;
        step();
        check("idle_state", {29'b0, fsm_state}, {29'b0, IDLE});

        // Fill from zero-wait bus with no consumer: four fetches then WAIT.
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h100 + 32'(4 * i));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("start_req", {31'b0, mem_req}, 32'd1);
        check("start_addr", mem_addr, 32'h100);
        repeat (5) step();
        check("fill_level", {29'b0, fifo_level}, 32'd4);
        check("fill_state", {29'b0, fsm_state}, {29'b0, WAIT});
        check("fill_req", {31'b0, mem_req}, 32'd0);
        check("fill_acks", addr_q.size(), 32'd0);

        // Continuous reads drain the whole frame in order, ending in DONE.
        for (int i = 4; i < 8; i++) addr_q.push_back(32'h100 + 32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            pix_rd = 1'b1;
            exp_q.push_back(24'h000100 + 24'(4 * i));
            step();
        end
        pix_rd = 1'b0;
        step();
        check("done_state", {29'b0, fsm_state}, {29'b0, DONE});
        check("done_req", {31'b0, mem_req}, 32'd0);
        check("done_level", {29'b0, fifo_level}, 32'd0);
        check("done_uf", {31'b0, underflow}, 32'd0);
        check("done_acks", addr_q.size(), 32'd0);

        // Underflow read on empty FIFO.
        pix_rd = 1'b1;
        exp_q.push_back(UF_RGB);
        step();
        pix_rd = 1'b0;
        check("uf_set", {31'b0, underflow}, 32'd1);
        step();
        check("uf_sticky", {31'b0, underflow}, 32'd1);
        check("uf_rgb_hold", {8'h0, rgb}, {8'h0, UF_RGB});

        // Restart clears underflow; refill, then restart while a slow request is pending.
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h100 + 32'(4 * i));
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("restart_uf_clear", {31'b0, underflow}, 32'd0);
        check("restart_addr", mem_addr, 32'h100);
        repeat (5) step();
        check("refill_state", {29'b0, fsm_state}, {29'b0, WAIT});
        ack_delay = 3;
        addr_q.push_back(32'h110);
        pix_rd = 1'b1;
        exp_q.push_back(24'h000100);
        step();
        pix_rd = 1'b0;
        wait_req("slow_req");
        check("slow_addr", mem_addr, 32'h110);
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("drain_state", {29'b0, fsm_state}, {29'b0, DRAIN});
        check("drain_level", {29'b0, fifo_level}, 32'd0);
        n = 0;
        while (fsm_state == DRAIN && n < 10) begin
            check("drain_req_hold", {31'b0, mem_req}, 32'd1);
            check("drain_addr_hold", mem_addr, 32'h110);
            step();
            n++;
        end
        check("after_drain_state", {29'b0, fsm_state}, {29'b0, REQ});
        check("after_drain_addr", mem_addr, 32'h100);
        check("after_drain_level", {29'b0, fifo_level}, 32'd0);
        check("drain_acks", addr_q.size(), 32'd0);

        // frame_start coincident with mem_ack and pix_rd.
        ack_delay = 0;
        for (int i = 0; i < 4; i++) addr_q.push_back(32'h100 + 32'(4 * i));
        repeat (5) step();
        check("refill2_level", {29'b0, fifo_level}, 32'd4);
        addr_q.push_back(32'h110);
        pix_rd = 1'b1;
        exp_q.push_back(24'h000100);
        step();
        pix_rd = 1'b0;
        wait_req("coinc_req");
        frame_start = 1'b1;
        pix_rd      = 1'b1;
        exp_q.push_back(24'h000000);
        step();
        frame_start = 1'b0;
        pix_rd      = 1'b0;
        ack_en      = 1'b0;
        check("coinc_level", {29'b0, fifo_level}, 32'd0);
        check("coinc_addr", mem_addr, 32'h100);
        check("coinc_req_on", {31'b0, mem_req}, 32'd1);
        check("coinc_state", {29'b0, fsm_state}, {29'b0, REQ});
        check("coinc_acks", addr_q.size(), 32'd0);

        // Asynchronous reset while a request is outstanding.
        pixel_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        pixel_rst = 1'b0;
        repeat (3) step();
        check("post_rst_req", {31'b0, mem_req}, 32'd0);
        check("post_rst_state", {29'b0, fsm_state}, {29'b0, IDLE});
        check("pixels_left", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
